// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings, ALU op enum and stage-register types for pipeline_core
package pipeline_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NOP
  } alu_op_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } fd_reg_t;

  typedef struct packed {
    logic    valid;
    logic    wr;
    alu_op_t op;
  } de_ctrl_t;

  typedef struct packed {
    logic valid;
    logic wr;
  } ew_ctrl_t;

  // Anything that is not one of the five R-type ALU encodings becomes a NOP.
  function automatic alu_op_t decode_op(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_t op;
    op = ALU_NOP;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FUNCT_ADD: op = ALU_ADD;
        FUNCT_SUB: op = ALU_SUB;
        FUNCT_AND: op = ALU_AND;
        FUNCT_OR:  op = ALU_OR;
        FUNCT_SLT: op = ALU_SLT;
        default:   op = ALU_NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/pipeline_if.sv
// rtl/pipeline_if.sv - instruction-memory and register-file bus between pipeline_core and its memories
interface pipeline_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32
);
  logic [PC_W-1:0]       pc;
  logic                  imem_valid;
  logic [31:0]           instruction;
  logic [REG_ADDR_W-1:0] rf_read_addr_1;
  logic [REG_ADDR_W-1:0] rf_read_addr_2;
  logic [DATA_W-1:0]     rf_read_data_1;
  logic [DATA_W-1:0]     rf_read_data_2;
  logic [REG_ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0]     rf_write_data;
  logic                  rf_write_en;

  modport master (
    output pc,
    input  imem_valid,
    input  instruction,
    output rf_read_addr_1,
    output rf_read_addr_2,
    input  rf_read_data_1,
    input  rf_read_data_2,
    output rf_write_addr,
    output rf_write_data,
    output rf_write_en
  );

  modport slave (
    input  pc,
    output imem_valid,
    output instruction,
    input  rf_read_addr_1,
    input  rf_read_addr_2,
    output rf_read_data_1,
    output rf_read_data_2,
    input  rf_write_addr,
    input  rf_write_data,
    input  rf_write_en
  );

endinterface

// File: rtl/pipeline_alu.sv
// rtl/pipeline_alu.sv - combinational ALU for the execute stage
module pipeline_alu
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = operand_a + operand_b;
      ALU_SUB: result = operand_a - operand_b;
      ALU_AND: result = operand_a & operand_b;
      ALU_OR:  result = operand_a | operand_b;
      ALU_SLT: result = DATA_W'($signed(operand_a) < $signed(operand_b));
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_core.sv
// rtl/pipeline_core.sv - four-stage fetch/decode/execute/writeback integer pipeline
// Define PIPELINE_FORWARD_EN to bypass E/W results into decode; otherwise hazards interlock.
module pipeline_core
  import pipeline_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              REG_ADDR_W = 5,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic       clock,
  input  logic       reset,
  pipeline_if.master bus,
  output logic       stall
);

  logic [PC_W-1:0]       pc_q, pc_d;
  fd_reg_t               fd_q, fd_d;
  de_ctrl_t              de_ctrl_q, de_ctrl_d;
  logic [REG_ADDR_W-1:0] de_rd_q, de_rd_d;
  logic [DATA_W-1:0]     de_a_q, de_a_d;
  logic [DATA_W-1:0]     de_b_q, de_b_d;
  ew_ctrl_t              ew_ctrl_q, ew_ctrl_d;
  logic [REG_ADDR_W-1:0] ew_rd_q, ew_rd_d;
  logic [DATA_W-1:0]     ew_result_q, ew_result_d;

  logic [REG_ADDR_W-1:0] dec_rs, dec_rt, dec_rd;
  alu_op_t               dec_op;
  logic [DATA_W-1:0]     opnd_a, opnd_b;
  logic [DATA_W-1:0]     alu_result;
  logic                  e_writes, w_writes;
  logic                  hit_e_rs, hit_e_rt, hit_w_rs, hit_w_rt;
  logic                  unused_shamt;

  assign dec_rs       = REG_ADDR_W'(fd_q.instr[25:21]);
  assign dec_rt       = REG_ADDR_W'(fd_q.instr[20:16]);
  assign dec_rd       = REG_ADDR_W'(fd_q.instr[15:11]);
  assign dec_op       = decode_op(fd_q.instr[31:26], fd_q.instr[5:0]);
  assign unused_shamt = ^fd_q.instr[10:6];

  assign bus.pc             = pc_q;
  assign bus.rf_read_addr_1 = dec_rs;
  assign bus.rf_read_addr_2 = dec_rt;
  assign bus.rf_write_addr  = ew_rd_q;
  assign bus.rf_write_data  = ew_result_q;
  assign bus.rf_write_en    = ew_ctrl_q.valid && ew_ctrl_q.wr && (ew_rd_q != '0);

  pipeline_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (de_ctrl_q.op),
    .operand_a (de_a_q),
    .operand_b (de_b_q),
    .result    (alu_result)
  );

  // Register 0 never matches: a non-zero source equal to a writer's rd implies rd != 0.
  assign e_writes = de_ctrl_q.valid && de_ctrl_q.wr;
  assign w_writes = ew_ctrl_q.valid && ew_ctrl_q.wr;
  assign hit_e_rs = fd_q.valid && (dec_rs != '0) && e_writes && (de_rd_q == dec_rs);
  assign hit_e_rt = fd_q.valid && (dec_rt != '0) && e_writes && (de_rd_q == dec_rt);
  assign hit_w_rs = fd_q.valid && (dec_rs != '0) && w_writes && (ew_rd_q == dec_rs);
  assign hit_w_rt = fd_q.valid && (dec_rt != '0) && w_writes && (ew_rd_q == dec_rt);

`ifdef PIPELINE_FORWARD_EN
  assign stall  = 1'b0;
  assign opnd_a = hit_e_rs ? alu_result : (hit_w_rs ? ew_result_q : bus.rf_read_data_1);
  assign opnd_b = hit_e_rt ? alu_result : (hit_w_rt ? ew_result_q : bus.rf_read_data_2);
`else
  assign stall  = hit_e_rs || hit_e_rt || hit_w_rs || hit_w_rt;
  assign opnd_a = bus.rf_read_data_1;
  assign opnd_b = bus.rf_read_data_2;
`endif

  always_comb begin
    pc_d = pc_q;
    fd_d = fd_q;
    if (!stall) begin
      if (bus.imem_valid) begin
        fd_d.valid = 1'b1;
        fd_d.instr = bus.instruction;
        pc_d       = pc_q + PC_W'(4);
      end else begin
        fd_d.valid = 1'b0;
      end
    end

    de_ctrl_d.valid = fd_q.valid && !stall;
    de_ctrl_d.wr    = (dec_op != ALU_NOP);
    de_ctrl_d.op    = dec_op;
    de_rd_d         = dec_rd;
    de_a_d          = opnd_a;
    de_b_d          = opnd_b;

    ew_ctrl_d.valid = de_ctrl_q.valid;
    ew_ctrl_d.wr    = de_ctrl_q.wr;
    ew_rd_d         = de_rd_q;
    ew_result_d     = alu_result;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      fd_q        <= '0;
      de_ctrl_q   <= '0;
      de_rd_q     <= '0;
      de_a_q      <= '0;
      de_b_q      <= '0;
      ew_ctrl_q   <= '0;
      ew_rd_q     <= '0;
      ew_result_q <= '0;
    end else begin
      pc_q        <= pc_d;
      fd_q        <= fd_d;
      de_ctrl_q   <= de_ctrl_d;
      de_rd_q     <= de_rd_d;
      de_a_q      <= de_a_d;
      de_b_q      <= de_b_d;
      ew_ctrl_q   <= ew_ctrl_d;
      ew_rd_q     <= ew_rd_d;
      ew_result_q <= ew_result_d;
    end
  end

endmodule

// File: tb/tb_pipeline_core.sv
// tb/tb_pipeline_core.sv - directed self-checking bench for pipeline_core (either PIPELINE_FORWARD_EN build)
module tb_pipeline_core;
  import pipeline_pkg::*;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PC_W       = 32;
`ifdef PIPELINE_FORWARD_EN
  localparam int STALL_ADJ = 0;
  localparam int STALL_GAP = 0;
`else
  localparam int STALL_ADJ = 2;
  localparam int STALL_GAP = 1;
`endif

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  logic stall;
  logic imem_valid = 1'b0;

  logic [31:0] imem [64];
  logic [31:0] rf [32];
  logic [31:0] rf_init [32];

  int nwrites = 0;
  int nzero   = 0;
  int nstall  = 0;
  int w0, z0, s0;
  int tests = 0;
  int fails = 0;

  pipeline_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W)) bus ();

  pipeline_core #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .PC_W       (PC_W),
    .RESET_PC   ('0)
  ) dut (
    .clock (clock),
    .reset (rstn),
    .bus   (bus),
    .stall (stall)
  );

  always #5 clock = ~clock;

  assign bus.imem_valid     = imem_valid;
  assign bus.instruction    = imem[bus.pc[7:2]];
  assign bus.rf_read_data_1 = rf[bus.rf_read_addr_1];
  assign bus.rf_read_data_2 = rf[bus.rf_read_addr_2];

  // Register-file model: reloads from rf_init while in reset, else writes on the strobe.
  always @(posedge clock) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init[i];
    end else if (bus.rf_write_en) begin
      rf[bus.rf_write_addr] <= bus.rf_write_data;
    end
    if (bus.rf_write_en) begin
      nwrites <= nwrites + 1;
      if (bus.rf_write_addr == '0) nzero <= nzero + 1;
    end
    if (stall) nstall <= nstall + 1;
  end

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          exp_w;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] enc(input logic [5:0] funct, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, funct};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_state(input logic [31:0] r1, input logic [31:0] r2);
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 32; i++) rf_init[i] = (i >= 3) ? 32'hDEADBEEF : 32'h0;
    rf_init[1] = r1;
    rf_init[2] = r2;
  endtask

  // Two reset cycles, then release: returns #1 into the first released cycle (pc = RESET_PC).
  task automatic start_run();
    imem_valid = 1'b1;
    rstn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    w0 = nwrites;
    z0 = nzero;
    s0 = nstall;
    rstn = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = '{"add",       FUNCT_ADD, 32'd5,        32'd7,        32'd12,       1};
    vecs[1] = '{"sub_neg",   FUNCT_SUB, 32'd5,        32'd7,        32'hFFFFFFFE, 1};
    vecs[2] = '{"and",       FUNCT_AND, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1};
    vecs[3] = '{"or",        FUNCT_OR,  32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1};
    vecs[4] = '{"slt_true",  FUNCT_SLT, 32'hFFFFFFFF, 32'd1,        32'd1,        1};
    vecs[5] = '{"slt_false", FUNCT_SLT, 32'd1,        32'hFFFFFFFF, 32'd0,        1};
    vecs[6] = '{"add_wrap",  FUNCT_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        1};
    vecs[7] = '{"sub_wrap",  FUNCT_SUB, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1};
    vecs[8] = '{"slt_min",   FUNCT_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1};
    vecs[9] = '{"nop_funct", 6'h21,     32'd5,        32'd7,        32'hDEADBEEF, 0};

    // Reset release, pc progression and first write latency.
    clear_state(32'd5, 32'd7);
    imem[0] = enc(FUNCT_ADD, 3, 1, 2);
    start_run();
    check("reset_pc", bus.pc, 32'd0);
    check("reset_wen", {31'b0, bus.rf_write_en}, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_waddr", {27'b0, bus.rf_write_addr}, 32'd0);
    check("reset_wdata", bus.rf_write_data, 32'd0);
    step();
    check("pc_c1", bus.pc, 32'd4);
    check("wen_c1", {31'b0, bus.rf_write_en}, 32'd0);
    step();
    check("pc_c2", bus.pc, 32'd8);
    check("wen_c2", {31'b0, bus.rf_write_en}, 32'd0);
    step();
    check("wen_c3", {31'b0, bus.rf_write_en}, 32'd1);
    check("waddr_c3", {27'b0, bus.rf_write_addr}, 32'd3);
    check("wdata_c3", bus.rf_write_data, 32'd12);

    // Single-instruction ALU vectors.
    for (int i = 0; i < 10; i++) begin
      clear_state(vecs[i].a, vecs[i].b);
      imem[0] = enc(vecs[i].funct, 3, 1, 2);
      start_run();
      repeat (8) step();
      check({vecs[i].name, "_r3"}, rf[3], vecs[i].exp);
      check({vecs[i].name, "_writes"}, 32'(nwrites - w0), 32'(vecs[i].exp_w));
    end

    // Back-to-back dependency on rs.
    clear_state(32'd5, 32'd7);
    imem[0] = enc(FUNCT_ADD, 3, 1, 2);
    imem[1] = enc(FUNCT_SUB, 4, 3, 1);
    start_run();
    repeat (12) step();
    check("adj_r3", rf[3], 32'd12);
    check("adj_r4", rf[4], 32'd7);
    check("adj_stalls", 32'(nstall - s0), 32'(STALL_ADJ));
    check("adj_writes", 32'(nwrites - w0), 32'd2);

    // One independent instruction between producer and consumer.
    clear_state(32'd5, 32'd7);
    imem[0] = enc(FUNCT_ADD, 3, 1, 2);
    imem[1] = enc(FUNCT_ADD, 9, 1, 1);
    imem[2] = enc(FUNCT_SUB, 4, 3, 1);
    start_run();
    repeat (12) step();
    check("gap_r4", rf[4], 32'd7);
    check("gap_r9", rf[9], 32'd10);
    check("gap_stalls", 32'(nstall - s0), 32'(STALL_GAP));

    // rs hazard against E, rt hazard against W at the same time.
    clear_state(32'd5, 32'd7);
    imem[0] = enc(FUNCT_ADD, 3, 1, 2);
    imem[1] = enc(FUNCT_ADD, 4, 1, 1);
    imem[2] = enc(FUNCT_ADD, 5, 4, 3);
    start_run();
    repeat (14) step();
    check("dual_r5", rf[5], 32'd22);
    check("dual_stalls", 32'(nstall - s0), 32'(STALL_ADJ));

    // Two writers of r3 in flight: the younger value must win.
    clear_state(32'd5, 32'd7);
    imem[0] = enc(FUNCT_ADD, 3, 1, 2);
    imem[1] = enc(FUNCT_ADD, 3, 1, 1);
    imem[2] = enc(FUNCT_ADD, 4, 3, 0);
    start_run();
    repeat (14) step();
    check("prio_r3", rf[3], 32'd10);
    check("prio_r4", rf[4], 32'd10);
    check("prio_stalls", 32'(nstall - s0), 32'(STALL_ADJ));

    // Writes to r0 are dropped and r0 is never forwarded.
    clear_state(32'd5, 32'd7);
    rf_init[6] = 32'h00001234;
    imem[0] = enc(FUNCT_ADD, 0, 1, 2);
    imem[1] = enc(FUNCT_ADD, 6, 0, 0);
    start_run();
    repeat (12) step();
    check("r0_zero_writes", 32'(nzero - z0), 32'd0);
    check("r0_r6", rf[6], 32'd0);
    check("r0_writes", 32'(nwrites - w0), 32'd1);
    check("r0_stalls", 32'(nstall - s0), 32'd0);

    // Fetch gap: imem_valid low for three cycles after the first instruction.
    clear_state(32'd5, 32'd7);
    imem[0] = enc(FUNCT_ADD, 3, 1, 2);
    imem[1] = enc(FUNCT_ADD, 4, 3, 2);
    start_run();
    step();
    imem_valid = 1'b0;
    check("gap_pc_c1", bus.pc, 32'd4);
    step();
    step();
    check("gap_pc_c3", bus.pc, 32'd4);
    step();
    check("gap_pc_c4", bus.pc, 32'd4);
    imem_valid = 1'b1;
    step();
    check("gap_pc_resume", bus.pc, 32'd8);
    repeat (8) step();
    check("fgap_r3", rf[3], 32'd12);
    check("fgap_r4", rf[4], 32'd19);
    check("fgap_writes", 32'(nwrites - w0), 32'd2);

    // Reset one cycle after issuing ADD r7 squashes it.
    clear_state(32'd5, 32'd7);
    rf_init[7] = 32'h00000077;
    imem[0] = enc(FUNCT_ADD, 7, 1, 2);
    start_run();
    step();
    rstn = 1'b0;
    imem_valid = 1'b0;
    step();
    check("rst_pc", bus.pc, 32'd0);
    check("rst_wen", {31'b0, bus.rf_write_en}, 32'd0);
    rstn = 1'b1;
    repeat (5) step();
    check("rst_writes", 32'(nwrites - w0), 32'd0);
    check("rst_r7", rf[7], 32'h00000077);
    check("rst_pc_held", bus.pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_core.md
# pipeline_core

Parametrised four-stage in-order integer pipeline (fetch, decode, execute, writeback) driving an external instruction memory and an external register file. It is the successor to the three-stage add-only datapath: it decodes five R-type ALU operations, accepts fetch backpressure via an instruction-valid input, and resolves read-after-write hazards by forwarding or, when forwarding is compiled out, by interlock. It sits between the instruction memory and the register file at the top of the processor.

## Interface
- DATA_W, 32, datapath and register width
- REG_ADDR_W, 5, register-file address width
- PC_W, 32, program-counter width
- RESET_PC, 0, PC value loaded on reset
- clock  input  1  clock, all state updates on rising edge
- reset  input  1  reset, synchronous, active-low
- pc  output  PC_W  fetch address to instruction memory
- imem_valid  input  1  instruction input holds valid data for the current pc
- instruction  input  32  instruction word for pc
- rf_read_addr_1 / rf_read_addr_2  output  REG_ADDR_W  rs / rt read addresses (combinational from decode stage)
- rf_read_data_1 / rf_read_data_2  input  DATA_W  combinational register-file read data
- rf_write_addr  output  REG_ADDR_W  writeback destination
- rf_write_data  output  DATA_W  writeback value
- rf_write_en  output  1  writeback strobe; register file writes on that rising edge
- stall  output  1  decode interlock active (status only)

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]; register fields truncated/zero-extended to REG_ADDR_W.
- Opcode 0 with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed compare, result 1 or 0); all arithmetic modulo 2^DATA_W, overflow ignored. Any other encoding is a NOP: travels down the pipe, never writes.
- Writes with rd = 0 are suppressed (rf_write_en stays 0).
- Fetch: when imem_valid=1 and stall=0, instruction latched into F/D with valid=1 and pc += 4 (wraps at 2^PC_W). imem_valid=0 and stall=0: F/D valid cleared, pc held. stall=1: F/D and pc held.
- Decode: reads rs/rt, resolves hazards, latches operands, rd, ALU op, write flag into D/E. On stall, D/E receives a bubble (valid=0).
- Execute: ALU result latched into E/W with rd and write flag.
- Writeback: rf_write_en = E/W valid AND write flag AND rd != 0.
- Hazard: decode source rs or rt (non-zero) equals rd of a writing instruction in E or W.
- Reset: pc=RESET_PC; all stage valids 0; rf_write_en=0, stall=0; data registers don't-care but rf_write_addr/rf_write_data driven 0.

## Timing
- Instruction accepted at edge n: decode cycle n+1, execute n+2, rf_write_en high in cycle n+3, register updated at end of n+3.
- Forwarding priority: E result over W result over register file; register 0 never forwarded.
- Reset asserted mid-stream: all in-flight instructions squashed at that edge; no write issued in the following cycle.
- Simultaneous hazard on rs and rt against different stages resolved independently.

## Configuration
- PIPELINE_FORWARD_EN defined: hazards resolved by bypass from E and W; stall is constant 0; dependent back-to-back instructions issue with zero bubbles.
- Undefined: no bypass paths; stall=1 while a hazard exists; consumer immediately after producer incurs exactly 2 bubbles, one instruction between them incurs 1.

## Structure
- Shared package pipeline_pkg: opcode/funct constants, alu_op_t enum (ADD, SUB, AND, OR, SLT, NOP), stage-register struct types.
- One sub-module: pipeline_alu (combinational, DATA_W-parametrised, op + two operands -> result).

## Test plan
- Reset held 2 cycles then released with imem_valid=1: pc = 0, 4, 8 on successive cycles; rf_write_en=0 until cycle 3 after release.
- r1=5, r2=7; ADD r3,r1,r2 then SUB r4,r3,r1 back-to-back: r3=12, r4=7; with PIPELINE_FORWARD_EN no stall, without it stall high 2 cycles.
- SLT r5,r1,r2 with r1=0xFFFFFFFF, r2=1: r5=1; AND/OR of 0xF0F0 and 0x0FF0 give 0x00F0 / 0xFFF0.
- ADD r0,r1,r2 followed by ADD r6,r0,r0: rf_write_en never high for r0; r6=0.
- imem_valid low for 3 cycles mid-stream: pc held, 3 bubbles, no spurious writes, following results correct.
- Reset asserted one cycle after issuing ADD r7: no write to r7; pc returns to RESET_PC.
